hpu_cmd_frontend: RTL

Per-HPU command issue stage that sits between one HPU core's command interface and the cluster/SoC command unit. Accepts command requests from the core, assigns each a local command ID from a pool of `NUM_HPU_CMDS` slots, and emits a `pspin_cmd_req_t` toward the command unit. It tracks completions arriving as `pspin_cmd_resp_t`, stores the immediate data returned with each completion, and serves non-blocking test and blocking wait queries from the core.

---
 rtl/hpu_cmd_frontend.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hpu_cmd_frontend.sv
// Per-HPU command issue stage: allocates local command IDs, registers the outgoing
// request toward the command unit, and tracks completions plus their immediate data.

package pspin_cmd_pkg;
  localparam int unsigned NUM_HPU_CMDS_DFLT = 4;
  localparam int unsigned CMD_LID_W         = $clog2(NUM_HPU_CMDS_DFLT);

  typedef logic [1:0]   pspin_cmd_type_t;
  typedef logic [1:0]   pspin_cmd_intf_id_t;
  typedef logic [607:0] pspin_cmd_descr_t;

  typedef struct packed {
    logic [1:0]           cluster_id;
    logic [2:0]           core_id;
    logic [CMD_LID_W-1:0] local_cmd_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    pspin_cmd_id_t      cmd_id;
    logic               generate_event;
    pspin_cmd_intf_id_t intf_id;
    pspin_cmd_type_t    cmd_type;
    pspin_cmd_descr_t   descr;
  } pspin_cmd_req_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [511:0]  imm_data;
  } pspin_cmd_resp_t;
endpackage

module hpu_cmd_frontend #(
  parameter int unsigned NUM_HPU_CMDS = pspin_cmd_pkg::NUM_HPU_CMDS_DFLT,
  localparam int unsigned LID_W = $clog2(NUM_HPU_CMDS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    cluster_id_i,
  input  logic [2:0]                    core_id_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [1:0]                    issue_intf_id_i,
  input  logic [1:0]                    issue_type_i,
  input  logic [607:0]                  issue_descr_i,
  input  logic                          issue_gen_event_i,
  output logic [LID_W-1:0]              issue_lid_o,
  output logic                          cmd_req_valid_o,
  input  logic                          cmd_req_ready_i,
  output pspin_cmd_pkg::pspin_cmd_req_t  cmd_req_o,
  input  logic                          cmd_resp_valid_i,
  input  pspin_cmd_pkg::pspin_cmd_resp_t cmd_resp_i,
  input  logic [LID_W-1:0]              test_lid_i,
  output logic                          test_done_o,
  input  logic                          wait_valid_i,
  input  logic [LID_W-1:0]              wait_lid_i,
  output logic                          wait_ready_o,
  output logic [511:0]                  wait_imm_o,
  output logic                          busy_o,
  output logic                          err_o
);

  logic [NUM_HPU_CMDS-1:0] busy_q, busy_d;
  logic [511:0]            imm_q [NUM_HPU_CMDS];
  logic                    req_valid_q, req_valid_d;
  pspin_cmd_pkg::pspin_cmd_req_t req_q, req_d;
  logic                    err_q, err_d;

  logic [LID_W-1:0] alloc_lid;
  logic             any_free;
  logic             issue_fire;
  logic             resp_hit;
  logic [LID_W-1:0] resp_lid;

  // Descending scan so the last hit, and therefore the winner, is the lowest free index.
  always_comb begin
    alloc_lid = '0;
    any_free  = 1'b0;
    for (int i = NUM_HPU_CMDS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_lid = LID_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  assign issue_ready_o = any_free & (~req_valid_q | cmd_req_ready_i);
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign issue_lid_o   = alloc_lid;

  assign resp_hit = cmd_resp_valid_i
                  & (cmd_resp_i.cmd_id.cluster_id == cluster_id_i)
                  & (cmd_resp_i.cmd_id.core_id == core_id_i);
  assign resp_lid = LID_W'(cmd_resp_i.cmd_id.local_cmd_id);

  // The allocated slot is always free, so issue and completion never touch the same bit.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (issue_fire) begin
      busy_d[alloc_lid] = 1'b1;
    end
    if (resp_hit) begin
      if (busy_q[resp_lid]) begin
        busy_d[resp_lid] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    req_valid_d = req_valid_q;
    req_d       = req_q;
    if (issue_fire) begin
      req_valid_d                 = 1'b1;
      req_d.cmd_id.cluster_id     = cluster_id_i;
      req_d.cmd_id.core_id        = core_id_i;
      req_d.cmd_id.local_cmd_id   = alloc_lid;
      req_d.generate_event        = issue_gen_event_i;
      req_d.intf_id               = issue_intf_id_i;
      req_d.cmd_type              = issue_type_i;
      req_d.descr                 = issue_descr_i;
    end else if (cmd_req_ready_i) begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_HPU_CMDS; i++) begin
        imm_q[i] <= '0;
      end
    end else if (resp_hit && busy_q[resp_lid]) begin
      imm_q[resp_lid] <= cmd_resp_i.imm_data;
    end
  end

  assign cmd_req_valid_o = req_valid_q;
  assign cmd_req_o       = req_q;
  assign test_done_o     = ~busy_q[test_lid_i];
  assign wait_ready_o    = wait_valid_i & ~busy_q[wait_lid_i];
  assign wait_imm_o      = imm_q[wait_lid_i];
  assign busy_o          = |busy_q;
  assign err_o           = err_q;

endmodule
